axi2per_bridge: RTL and testbench
=================================

# axi2per_bridge

AXI4 slave to cluster peripheral-interconnect master bridge: the inbound counterpart of the cluster's outbound peripheral-to-AXI path. It accepts AXI read and write bursts from the SoC side and replays them as single 32-bit transactions on the XBAR_PERIPH_BUS, one beat at a time. It then returns peripheral responses as AXI R beats and B responses. It sits between the cluster AXI slave port and the peripheral interconnect.

## Interface
- AXI_ADDR_WIDTH, 32, AXI address width
- AXI_DATA_WIDTH, 64, AXI data width; only 64 supported
- AXI_USER_WIDTH, 6, user width; user outputs driven 0
- AXI_ID_WIDTH, 6, AXI ID width
- PER_ADDR_WIDTH, 32, peripheral address width
- PER_ID_WIDTH, 5, peripheral ID width; id driven constant 0
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- test_en_i  in  1  test mode; no functional effect
- axi_slave  AXI_BUS.Slave  —  AXI4 slave port (AW, W, B, AR, R)
- periph_master  XBAR_PERIPH_BUS.Master  —  req/add/wen/wdata/be/id/gnt, r_valid/r_opc/r_id/r_rdata
- busy_o  out  1  high when state ≠ IDLE or aw_valid/ar_valid pending

## Operation
- FSM states: IDLE, WR_REQ, WR_WAIT, WR_RESP, RD_REQ, RD_WAIT, RD_DATA.
- IDLE: aw_ready and ar_ready are mutually exclusive. With both valid, the side other than the last served wins. The last-served flag resets to "read", so write wins first. The handshake latches id, addr, len, size and burst, and clears the beat counter and error flag.
- WR_REQ: per req = w_valid; add = current address; wen = 0; wdata = w_data[63:32] if addr[2] else w_data[31:0]; be = matching 4 strb bits. w_ready = gnt. On handshake → WR_WAIT.
- WR_WAIT: on r_valid, OR the error flag with r_opc. If beat count == len → WR_RESP; else advance address and → WR_REQ.
- WR_RESP: b_valid = 1; b_id = latched id; b_resp = SLVERR if error flag else OKAY. On b_ready → IDLE.
- RD_REQ: req = 1, wen = 1. On gnt → RD_WAIT.
- RD_WAIT: on r_valid, register r_rdata replicated into both 32-bit halves and register r_opc → RD_DATA.
- RD_DATA: r_valid = 1; r_id = latched id; r_last = (beat count == len); r_resp per beat. On r_ready: if last → IDLE, else advance and → RD_REQ.
- Address advance: INCR and WRAP add 1<<size (WRAP treated as INCR); FIXED holds the address. Width is AXI_ADDR_WIDTH, wrapping modulo 2^AXI_ADDR_WIDTH.
- size == 3: no peripheral access. Writes consume all len+1 W beats (w_ready = 1 in WR_REQ), then B = SLVERR. Reads return len+1 beats of SLVERR with data 0.
- The 8-bit beat counter governs burst end; incoming w_last is ignored.
- One burst in flight at a time; peripheral has at most one outstanding request.

## Timing
- Reset: all valids, readies, per req and busy_o are 0. Outputs: state IDLE, data/resp/id registers 0, wen 1.
- Single write with gnt immediate and r_valid one cycle after gnt: AW handshake at cycle 0, req+W at cycle 1, r_valid at cycle 2, b_valid at cycle 3.
- Single read: AR handshake at cycle 0, req at cycle 1, r_valid(per) at cycle 2, R valid at cycle 3. The next burst beat requests the cycle after the R handshake.
- req, add, wen, wdata and be are held stable until gnt.
- Reset asserted mid-burst returns to IDLE immediately. Pending AXI and peripheral transactions are dropped.

## Configuration
- AXI2PER_ERR_RESP_EN defined: r_opc maps to SLVERR on R/B as above.
- Not defined: r_opc is ignored and all peripheral responses return OKAY. The size == 3 SLVERR is retained.

## Test plan
- Single write, addr 0x1000_0004, w_data 0xAAAA_BBBB_CCCC_DDDD, strb 0xF0 → per add 0x1000_0004, wdata 0xAAAA_BBBB, be 0xF, wen 0; B OKAY with id echoed, b_valid 3 cycles after AW.
- INCR read, len 3, size 2, addr 0x100, r_rdata 1,2,3,4 → per adds 0x100/104/108/10C; R data 0x1_00000001…; r_last only on 4th beat.
- aw_valid and ar_valid both asserted in IDLE twice in a row → write served first, then read; busy_o high throughout.
- With AXI2PER_ERR_RESP_EN: 2-beat write, r_opc=1 on beat 0 → B SLVERR. Without the macro → B OKAY.
- size 3 write len 1 → zero per requests, both W beats accepted, B SLVERR.
- gnt held low 5 cycles during RD_REQ, then reset asserted → all outputs return to reset values the same cycle; next AR served normally.

Source files
------------

// File: rtl/axi2per_bridge.sv
// AXI4 slave to peripheral-interconnect master bridge: bursts are replayed as single 32-bit peripheral beats.
// Optional macro AXI2PER_ERR_RESP_EN: peripheral r_opc errors become SLVERR on R/B (otherwise always OKAY).
module axi2per_bridge #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_USER_WIDTH = 6,
    parameter int AXI_ID_WIDTH   = 6,
    parameter int PER_ADDR_WIDTH = 32,
    parameter int PER_ID_WIDTH   = 5
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        test_en_i,
    // AXI write address
    input  logic                        axi_aw_valid_i,
    output logic                        axi_aw_ready_o,
    input  logic [AXI_ID_WIDTH-1:0]     axi_aw_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr_i,
    input  logic [7:0]                  axi_aw_len_i,
    input  logic [2:0]                  axi_aw_size_i,
    input  logic [1:0]                  axi_aw_burst_i,
    // AXI write data
    input  logic                        axi_w_valid_i,
    output logic                        axi_w_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_w_data_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb_i,
    input  logic                        axi_w_last_i,
    // AXI write response
    output logic                        axi_b_valid_o,
    input  logic                        axi_b_ready_i,
    output logic [AXI_ID_WIDTH-1:0]     axi_b_id_o,
    output logic [1:0]                  axi_b_resp_o,
    output logic [AXI_USER_WIDTH-1:0]   axi_b_user_o,
    // AXI read address
    input  logic                        axi_ar_valid_i,
    output logic                        axi_ar_ready_o,
    input  logic [AXI_ID_WIDTH-1:0]     axi_ar_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr_i,
    input  logic [7:0]                  axi_ar_len_i,
    input  logic [2:0]                  axi_ar_size_i,
    input  logic [1:0]                  axi_ar_burst_i,
    // AXI read data
    output logic                        axi_r_valid_o,
    input  logic                        axi_r_ready_i,
    output logic [AXI_ID_WIDTH-1:0]     axi_r_id_o,
    output logic [AXI_DATA_WIDTH-1:0]   axi_r_data_o,
    output logic [1:0]                  axi_r_resp_o,
    output logic                        axi_r_last_o,
    output logic [AXI_USER_WIDTH-1:0]   axi_r_user_o,
    // peripheral master
    output logic                        per_req_o,
    output logic [PER_ADDR_WIDTH-1:0]   per_add_o,
    output logic                        per_wen_o,
    output logic [31:0]                 per_wdata_o,
    output logic [3:0]                  per_be_o,
    output logic [PER_ID_WIDTH-1:0]     per_id_o,
    input  logic                        per_gnt_i,
    input  logic                        per_r_valid_i,
    input  logic                        per_r_opc_i,
    input  logic [PER_ID_WIDTH-1:0]     per_r_id_i,
    input  logic [31:0]                 per_r_rdata_i,
    // status
    output logic                        busy_o,
    output logic [2:0]                  state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_WAIT = 3'd2,
        WR_RESP = 3'd3,
        RD_REQ  = 3'd4,
        RD_WAIT = 3'd5,
        RD_DATA = 3'd6
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    state_e                      state_q, state_d;
    logic [AXI_ID_WIDTH-1:0]     id_q, id_d;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]                  len_q, len_d;
    logic [2:0]                  size_q, size_d;
    logic [1:0]                  burst_q, burst_d;
    logic [7:0]                  beat_q, beat_d;
    logic                        err_q, err_d;
    logic                        last_wr_q, last_wr_d;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]                  rresp_q, rresp_d;

    logic                        per_err;
    logic                        no_access;
    logic                        last_beat;
    logic [AXI_ADDR_WIDTH-1:0]   next_addr;
    logic                        unused_signals;

`ifdef AXI2PER_ERR_RESP_EN
    assign per_err = per_r_opc_i;
`else
    assign per_err = 1'b0;
`endif

    assign unused_signals = ^{test_en_i, axi_w_last_i, per_r_id_i, per_r_opc_i};

    // 64-bit beats cannot be carried by a 32-bit peripheral: such bursts are answered locally.
    assign no_access = (size_q == 3'd3);
    assign last_beat = (beat_q == len_q);
    assign next_addr = (burst_q == BURST_FIXED) ? addr_q
                                                : addr_q + (AXI_ADDR_WIDTH'(1) << size_q);

    // Handshakes: a transfer happens in the cycle where valid and ready are both high.
    // AW/AR readiness depends on the opposing valid to arbitrate fairly between them.
    assign axi_aw_ready_o = (state_q == IDLE) && axi_aw_valid_i && (!axi_ar_valid_i || !last_wr_q);
    assign axi_ar_ready_o = (state_q == IDLE) && axi_ar_valid_i && !axi_aw_ready_o;
    assign axi_w_ready_o  = (state_q == WR_REQ) && (no_access || per_gnt_i);

    assign axi_b_valid_o  = (state_q == WR_RESP);
    assign axi_b_id_o     = id_q;
    assign axi_b_resp_o   = err_q ? RESP_SLVERR : RESP_OKAY;
    assign axi_b_user_o   = '0;

    assign axi_r_valid_o  = (state_q == RD_DATA);
    assign axi_r_id_o     = id_q;
    assign axi_r_data_o   = rdata_q;
    assign axi_r_resp_o   = rresp_q;
    assign axi_r_last_o   = (state_q == RD_DATA) && last_beat;
    assign axi_r_user_o   = '0;

    assign per_req_o   = ((state_q == WR_REQ) && !no_access && axi_w_valid_i) || (state_q == RD_REQ);
    assign per_add_o   = PER_ADDR_WIDTH'(addr_q);
    assign per_wen_o   = (state_q != WR_REQ);
    assign per_wdata_o = (state_q == WR_REQ) ? (addr_q[2] ? axi_w_data_i[63:32] : axi_w_data_i[31:0]) : 32'd0;
    assign per_be_o    = (state_q == WR_REQ) ? (addr_q[2] ? axi_w_strb_i[7:4] : axi_w_strb_i[3:0]) : 4'd0;
    assign per_id_o    = '0;

    assign busy_o  = (state_q != IDLE) || axi_aw_valid_i || axi_ar_valid_i;
    assign state_o = state_q;

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        err_d     = err_q;
        last_wr_d = last_wr_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (state_q)
            IDLE: begin
                if (axi_aw_valid_i && axi_aw_ready_o) begin
                    id_d      = axi_aw_id_i;
                    addr_d    = axi_aw_addr_i;
                    len_d     = axi_aw_len_i;
                    size_d    = axi_aw_size_i;
                    burst_d   = axi_aw_burst_i;
                    beat_d    = 8'd0;
                    err_d     = (axi_aw_size_i == 3'd3);
                    last_wr_d = 1'b1;
                    state_d   = WR_REQ;
                end else if (axi_ar_valid_i && axi_ar_ready_o) begin
                    id_d      = axi_ar_id_i;
                    addr_d    = axi_ar_addr_i;
                    len_d     = axi_ar_len_i;
                    size_d    = axi_ar_size_i;
                    burst_d   = axi_ar_burst_i;
                    beat_d    = 8'd0;
                    err_d     = 1'b0;
                    last_wr_d = 1'b0;
                    if (axi_ar_size_i == 3'd3) begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                        state_d = RD_DATA;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (axi_w_valid_i && axi_w_ready_o) begin
                    if (!no_access) begin
                        state_d = WR_WAIT;
                    end else if (last_beat) begin
                        state_d = WR_RESP;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            WR_WAIT: begin
                if (per_r_valid_i) begin
                    err_d = err_q | per_err;
                    if (last_beat) begin
                        state_d = WR_RESP;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        addr_d  = next_addr;
                        state_d = WR_REQ;
                    end
                end
            end
            WR_RESP: begin
                if (axi_b_ready_i) state_d = IDLE;
            end
            RD_REQ: begin
                if (per_gnt_i) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (per_r_valid_i) begin
                    rdata_d = {per_r_rdata_i, per_r_rdata_i};
                    rresp_d = per_err ? RESP_SLVERR : RESP_OKAY;
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (axi_r_ready_i) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        addr_d  = next_addr;
                        state_d = no_access ? RD_DATA : RD_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
            last_wr_q <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
            last_wr_q <= last_wr_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

endmodule

// File: tb/tb_axi2per_bridge.sv
// Directed bench for axi2per_bridge: writes, reads, arbitration, size-3 and error bursts, mid-burst reset.
module tb_axi2per_bridge;

`ifdef AXI2PER_ERR_RESP_EN
    localparam logic [1:0] ERR_RESP = 2'b10;
`else
    localparam logic [1:0] ERR_RESP = 2'b00;
`endif
    localparam logic [1:0] INCR = 2'b01;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        aw_valid = 0, aw_ready;
    logic [5:0]  aw_id = 0;
    logic [31:0] aw_addr = 0;
    logic [7:0]  aw_len = 0;
    logic [2:0]  aw_size = 0;
    logic [1:0]  aw_burst = 0;
    logic        w_valid = 0, w_ready, w_last = 0;
    logic [63:0] w_data = 0;
    logic [7:0]  w_strb = 0;
    logic        b_valid, b_ready = 0;
    logic [5:0]  b_id, b_user;
    logic [1:0]  b_resp;
    logic        ar_valid = 0, ar_ready;
    logic [5:0]  ar_id = 0;
    logic [31:0] ar_addr = 0;
    logic [7:0]  ar_len = 0;
    logic [2:0]  ar_size = 0;
    logic [1:0]  ar_burst = 0;
    logic        r_valid, r_ready = 0, r_last;
    logic [5:0]  r_id, r_user;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        p_req, p_wen, p_gnt = 0, p_rvalid = 0, p_opc = 0;
    logic [31:0] p_add, p_wdata, p_rdata = 0;
    logic [3:0]  p_be;
    logic [4:0]  p_id, p_rid = 0;
    logic        busy;
    logic [2:0]  state;

    int n_checks = 0;
    int n_fails  = 0;

    axi2per_bridge dut (
        .clk_i(clk), .rst_ni(rst_n), .test_en_i(1'b0),
        .axi_aw_valid_i(aw_valid), .axi_aw_ready_o(aw_ready), .axi_aw_id_i(aw_id),
        .axi_aw_addr_i(aw_addr), .axi_aw_len_i(aw_len), .axi_aw_size_i(aw_size), .axi_aw_burst_i(aw_burst),
        .axi_w_valid_i(w_valid), .axi_w_ready_o(w_ready), .axi_w_data_i(w_data),
        .axi_w_strb_i(w_strb), .axi_w_last_i(w_last),
        .axi_b_valid_o(b_valid), .axi_b_ready_i(b_ready), .axi_b_id_o(b_id),
        .axi_b_resp_o(b_resp), .axi_b_user_o(b_user),
        .axi_ar_valid_i(ar_valid), .axi_ar_ready_o(ar_ready), .axi_ar_id_i(ar_id),
        .axi_ar_addr_i(ar_addr), .axi_ar_len_i(ar_len), .axi_ar_size_i(ar_size), .axi_ar_burst_i(ar_burst),
        .axi_r_valid_o(r_valid), .axi_r_ready_i(r_ready), .axi_r_id_o(r_id), .axi_r_data_o(r_data),
        .axi_r_resp_o(r_resp), .axi_r_last_o(r_last), .axi_r_user_o(r_user),
        .per_req_o(p_req), .per_add_o(p_add), .per_wen_o(p_wen), .per_wdata_o(p_wdata),
        .per_be_o(p_be), .per_id_o(p_id), .per_gnt_i(p_gnt), .per_r_valid_i(p_rvalid),
        .per_r_opc_i(p_opc), .per_r_id_i(p_rid), .per_r_rdata_i(p_rdata),
        .busy_o(busy), .state_o(state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write burst with size < 3; opc_beat selects the beat answered with r_opc = 1 (8'hFF: none).
    task automatic wr_burst(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [63:0] data, input logic [7:0] strb,
                            input logic [7:0] opc_beat, input logic [1:0] exp_resp);
        logic [31:0] a;
        logic [63:0] d;
        a = addr;
        aw_valid = 1; aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = INCR;
        #1;
        chk("aw_ready", aw_ready, 1);
        chk("ar_ready_excl_w", ar_ready, 0);
        chk("busy_aw", busy, 1);
        tick();
        aw_valid = 0;
        for (int i = 0; i <= int'(len); i++) begin
            d = data + 64'(i);
            w_valid = 1; w_data = d; w_strb = strb; p_gnt = 1;
            #1;
            chk("wr_req", p_req, 1);
            chk("wr_add", p_add, a);
            chk("wr_wen", p_wen, 0);
            chk("wr_wdata", p_wdata, a[2] ? d[63:32] : d[31:0]);
            chk("wr_be", p_be, a[2] ? strb[7:4] : strb[3:0]);
            chk("w_ready", w_ready, 1);
            tick();
            w_valid = 0; p_gnt = 0; p_rvalid = 1; p_opc = (i == int'(opc_beat));
            #1;
            chk("wr_wait_req", p_req, 0);
            chk("wr_wait_bvalid", b_valid, 0);
            tick();
            p_rvalid = 0; p_opc = 0;
            a = a + (32'd1 << size);
        end
        #1;
        chk("b_valid", b_valid, 1);
        chk("b_id", b_id, id);
        chk("b_resp", b_resp, exp_resp);
        b_ready = 1;
        tick();
        b_ready = 0;
        #1;
        chk("b_valid_done", b_valid, 0);
    endtask

    // Read burst; size 3 expects locally generated SLVERR beats with zero data.
    task automatic rd_burst(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [31:0] rbase, input logic [7:0] opc_beat);
        logic [31:0] a;
        logic [31:0] rd;
        a = addr;
        ar_valid = 1; ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = INCR;
        #1;
        chk("ar_ready", ar_ready, 1);
        chk("aw_ready_excl_r", aw_ready, 0);
        tick();
        ar_valid = 0;
        for (int i = 0; i <= int'(len); i++) begin
            rd = rbase + 32'(i);
            if (size != 3'd3) begin
                p_gnt = 1;
                #1;
                chk("rd_req", p_req, 1);
                chk("rd_wen", p_wen, 1);
                chk("rd_add", p_add, a);
                tick();
                p_gnt = 0; p_rvalid = 1; p_rdata = rd; p_opc = (i == int'(opc_beat));
                #1;
                chk("rd_wait_rvalid", r_valid, 0);
                tick();
                p_rvalid = 0; p_opc = 0;
            end
            #1;
            chk("r_valid", r_valid, 1);
            chk("r_data", r_data, (size == 3'd3) ? 64'd0 : {rd, rd});
            chk("r_last", r_last, (i == int'(len)));
            chk("r_id", r_id, id);
            chk("r_resp", r_resp, (size == 3'd3) ? 2'b10 : ((i == int'(opc_beat)) ? ERR_RESP : 2'b00));
            r_ready = 1;
            tick();
            r_ready = 0;
            a = a + (32'd1 << size);
        end
        #1;
        chk("r_valid_done", r_valid, 0);
        chk("rd_state_idle", state, 0);
    endtask

    initial begin
        // reset values
        repeat (2) tick();
        chk("rst_aw_ready", aw_ready, 0);
        chk("rst_ar_ready", ar_ready, 0);
        chk("rst_w_ready", w_ready, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_req", p_req, 0);
        chk("rst_wen", p_wen, 1);
        chk("rst_busy", busy, 0);
        chk("rst_state", state, 0);
        chk("rst_r_data", r_data, 0);
        chk("rst_b_resp", b_resp, 0);
        chk("rst_ids_users", {b_id, r_id, b_user, r_user, p_id}, 0);
        rst_n = 1;
        tick();

        // single write to the upper half of a 64-bit word
        wr_burst(6'h2A, 32'h1000_0004, 8'd0, 3'd2, 64'hAAAA_BBBB_CCCC_DDDD, 8'hF0, 8'hFF, 2'b00);

        // INCR read, 4 beats of 32 bits
        rd_burst(6'h05, 32'h0000_0100, 8'd3, 3'd2, 32'd1, 8'hFF);

        // both AW and AR pending twice: write first, then read, then the held write
        ar_valid = 1; ar_id = 6'h11; ar_addr = 32'h0000_0800; ar_len = 0; ar_size = 2; ar_burst = INCR;
        wr_burst(6'h12, 32'h0000_0900, 8'd0, 3'd2, 64'h0123_4567_89AB_CDEF, 8'h0F, 8'hFF, 2'b00);
        aw_valid = 1; aw_id = 6'h13; aw_addr = 32'h0000_0A00; aw_len = 0; aw_size = 2; aw_burst = INCR;
        #1;
        chk("arb_busy_idle", busy, 1);
        chk("arb_ar_wins", ar_ready, 1);
        chk("arb_aw_waits", aw_ready, 0);
        rd_burst(6'h11, 32'h0000_0800, 8'd0, 3'd2, 32'h5555_0000, 8'hFF);
        chk("arb_busy_aw_pending", busy, 1);
        wr_burst(6'h13, 32'h0000_0A00, 8'd0, 3'd2, 64'h1111_2222_3333_4444, 8'hFF, 8'hFF, 2'b00);
        #1;
        chk("arb_busy_end", busy, 0);

        // two-beat write with a peripheral error on beat 0
        wr_burst(6'h21, 32'h0000_0400, 8'd1, 3'd2, 64'hDEAD_BEEF_0000_0000, 8'hFF, 8'd0, ERR_RESP);

        // size 3 write, len 1: no peripheral traffic, SLVERR
        aw_valid = 1; aw_id = 6'h07; aw_addr = 32'h0000_0300; aw_len = 1; aw_size = 3; aw_burst = INCR;
        #1;
        chk("s3w_aw_ready", aw_ready, 1);
        tick();
        aw_valid = 0; w_valid = 1; w_data = 64'hFFFF_FFFF_FFFF_FFFF; w_strb = 8'hFF;
        #1;
        chk("s3w_w_ready0", w_ready, 1);
        chk("s3w_req0", p_req, 0);
        tick();
        #1;
        chk("s3w_w_ready1", w_ready, 1);
        chk("s3w_req1", p_req, 0);
        tick();
        w_valid = 0;
        #1;
        chk("s3w_b_valid", b_valid, 1);
        chk("s3w_b_resp", b_resp, 2'b10);
        chk("s3w_b_id", b_id, 6'h07);
        b_ready = 1;
        tick();
        b_ready = 0;

        // size 3 read, len 1: two SLVERR beats with zero data
        rd_burst(6'h08, 32'h0000_0600, 8'd1, 3'd3, 32'd0, 8'hFF);

        // peripheral error on a single read beat
        rd_burst(6'h09, 32'h0000_0700, 8'd0, 3'd2, 32'hCAFE_F00D, 8'd0);

        // gnt withheld in RD_REQ, then asynchronous reset mid-burst
        ar_valid = 1; ar_id = 6'h3F; ar_addr = 32'h0000_0200; ar_len = 1; ar_size = 2; ar_burst = INCR;
        tick();
        ar_valid = 0; p_gnt = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_req", p_req, 1);
            chk("stall_add", p_add, 32'h0000_0200);
            tick();
        end
        rst_n = 0;
        #1;
        chk("mid_rst_req", p_req, 0);
        chk("mid_rst_wen", p_wen, 1);
        chk("mid_rst_state", state, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_r_valid", r_valid, 0);
        chk("mid_rst_add", p_add, 0);
        tick();
        rst_n = 1;
        tick();
        rd_burst(6'h03, 32'h0000_0500, 8'd0, 3'd2, 32'h1234_5678, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
